// File: rtl/mips_pkg.sv
// Shared opcodes, control-bus encodings and default widths for the MIPS ID stage.
// Pure declarations: no latency, no flow control.
package mips_pkg;

    localparam int LEN_DEF        = 32;
    localparam int NB_ADDR_DEF    = 5;
    localparam int NB_CTRL_EX_DEF = 4;
    localparam int NB_CTRL_M_DEF  = 3;
    localparam int NB_CTRL_WB_DEF = 2;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    // ex = {RegDst, ALUOp[1:0], ALUSrc}, m = {Branch, MemRead, MemWrite}, wb = {RegWrite, MemtoReg}
    typedef struct packed {
        logic [NB_CTRL_EX_DEF-1:0] ex;
        logic [NB_CTRL_M_DEF-1:0]  m;
        logic [NB_CTRL_WB_DEF-1:0] wb;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP    = 9'b0000_000_00;
    localparam ctrl_t CTRL_RTYPE  = 9'b1100_000_10;
    localparam ctrl_t CTRL_LW     = 9'b0001_010_11;
    localparam ctrl_t CTRL_SW     = 9'b0001_001_00;
    localparam ctrl_t CTRL_ADDI   = 9'b0001_000_10;
    localparam ctrl_t CTRL_BRANCH = 9'b0010_100_00;

    function automatic ctrl_t decode_ctrl(input logic [5:0] opcode);
        ctrl_t c;
        case (opcode)
            OP_RTYPE:       c = CTRL_RTYPE;
            OP_LW:          c = CTRL_LW;
            OP_SW:          c = CTRL_SW;
            OP_ADDI:        c = CTRL_ADDI;
            OP_BEQ, OP_BNE: c = CTRL_BRANCH;
            default:        c = CTRL_NOP;
        endcase
        return c;
    endfunction

    // Opcodes whose rt field is a source operand rather than a destination.
    function automatic logic reads_rt(input logic [5:0] opcode);
        return (opcode == OP_RTYPE) || (opcode == OP_SW) ||
               (opcode == OP_BEQ)   || (opcode == OP_BNE);
    endfunction

endpackage

// File: rtl/mips_regfile.sv
// 2**NB_ADDR x LEN register file, r0 hardwired to zero, write-through bypass on reads.
// Reads combinational, writes take effect on the rising edge; never stalls.
module mips_regfile #(
    parameter int LEN     = 32,
    parameter int NB_ADDR = 5
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_we,
    input  logic [NB_ADDR-1:0] i_waddr,
    input  logic [LEN-1:0]     i_wdata,
    input  logic [NB_ADDR-1:0] i_raddr_1,
    input  logic [NB_ADDR-1:0] i_raddr_2,
    output logic [LEN-1:0]     o_rdata_1,
    output logic [LEN-1:0]     o_rdata_2
);

    localparam int NREG = 2**NB_ADDR;

    logic [LEN-1:0] regs_q [NREG];
    logic [LEN-1:0] regs_d [NREG];

    always_comb begin
        regs_d = regs_q;
        if (i_we && (i_waddr != '0)) begin
            regs_d[i_waddr] = i_wdata;
        end
    end

    // regs_d already carries this cycle's write, so reading it gives the bypass for free.
    always_comb begin
        o_rdata_1 = (i_raddr_1 == '0) ? '0 : regs_d[i_raddr_1];
        o_rdata_2 = (i_raddr_2 == '0) ? '0 : regs_d[i_raddr_2];
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

endmodule

// File: rtl/seg_instruction_decode_hz.sv
// MIPS ID stage: decode, register read, load-use/branch hazard detection, early branch/jump resolution.
// ID/EX registered (latency 1); o_stall holds PC and IF/ID and injects a bubble into ID/EX.
module seg_instruction_decode_hz
    import mips_pkg::*;
#(
    parameter int LEN        = LEN_DEF,
    parameter int NB_ADDR    = NB_ADDR_DEF,
    parameter int NB_CTRL_EX = NB_CTRL_EX_DEF,
    parameter int NB_CTRL_M  = NB_CTRL_M_DEF,
    parameter int NB_CTRL_WB = NB_CTRL_WB_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    input  logic [LEN-1:0]        i_PC,
    input  logic [LEN-1:0]        i_instruc,
    input  logic [NB_ADDR-1:0]    i_write_reg,
    input  logic [LEN-1:0]        i_write_data,
    input  logic                  i_RegWrite,
    input  logic                  i_ex_MemRead,
    input  logic                  i_ex_RegWrite,
    input  logic [NB_ADDR-1:0]    i_ex_wreg,
    input  logic                  i_mem_RegWrite,
    input  logic [NB_ADDR-1:0]    i_mem_wreg,
    output logic                  o_stall,
    output logic                  o_flush,
    output logic                  o_jump,
    output logic                  o_branch_taken,
    output logic [LEN-1:0]        o_dir_jump,
    output logic [LEN-1:0]        o_branch_target,
    output logic                  o_valid,
    output logic [LEN-1:0]        o_PC,
    output logic [LEN-1:0]        o_read_data_1,
    output logic [LEN-1:0]        o_read_data_2,
    output logic [LEN-1:0]        o_addr_ext,
    output logic [NB_ADDR-1:0]    o_rs,
    output logic [NB_ADDR-1:0]    o_rt,
    output logic [NB_ADDR-1:0]    o_rd,
    output logic [NB_CTRL_WB-1:0] o_ctrl_wb_bus,
    output logic [NB_CTRL_M-1:0]  o_ctrl_mem_bus,
    output logic [NB_CTRL_EX-1:0] o_ctrl_exc_bus,
    output logic [15:0]           o_stall_count
);

    typedef struct packed {
        logic                  valid;
        logic [LEN-1:0]        pc;
        logic [LEN-1:0]        rd1;
        logic [LEN-1:0]        rd2;
        logic [LEN-1:0]        ext;
        logic [NB_ADDR-1:0]    rs;
        logic [NB_ADDR-1:0]    rt;
        logic [NB_ADDR-1:0]    rd;
        logic [NB_CTRL_WB-1:0] wb;
        logic [NB_CTRL_M-1:0]  m;
        logic [NB_CTRL_EX-1:0] ex;
    } idex_t;

    logic [5:0]         opcode;
    logic [NB_ADDR-1:0] rs, rt, rd;
    logic [LEN-1:0]     rd1, rd2, addr_ext;
    ctrl_t              ctrl;
    logic               is_branch, load_use, branch_haz, issue;
    idex_t              idex_d, idex_q;
    logic [15:0]        stall_count_d, stall_count_q;

    assign opcode   = i_instruc[31:26];
    assign rs       = i_instruc[25:21];
    assign rt       = i_instruc[20:16];
    assign rd       = i_instruc[15:11];
    assign addr_ext = {{(LEN-16){i_instruc[15]}}, i_instruc[15:0]};
    assign ctrl     = decode_ctrl(opcode);

    mips_regfile #(.LEN(LEN), .NB_ADDR(NB_ADDR)) u_regfile (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_we      (i_RegWrite),
        .i_waddr   (i_write_reg),
        .i_wdata   (i_write_data),
        .i_raddr_1 (rs),
        .i_raddr_2 (rt),
        .o_rdata_1 (rd1),
        .o_rdata_2 (rd2)
    );

    // Branches compare in ID, so any in-flight producer of their operands must drain first.
    always_comb begin
        is_branch  = (opcode == OP_BEQ) || (opcode == OP_BNE);
        load_use   = i_valid && i_ex_MemRead && (i_ex_wreg != '0) &&
                     ((i_ex_wreg == rs) || ((i_ex_wreg == rt) && reads_rt(opcode)));
        branch_haz = i_valid && is_branch &&
                     ((i_ex_RegWrite && (i_ex_wreg != '0) && ((i_ex_wreg == rs) || (i_ex_wreg == rt))) ||
                      (i_mem_RegWrite && (i_mem_wreg != '0) && ((i_mem_wreg == rs) || (i_mem_wreg == rt))));
        // Everything combinational is gated by reset so outputs read zero while held in reset.
        o_stall        = i_rst && (load_use || branch_haz);
        issue          = i_rst && i_valid && !o_stall;
        o_branch_taken = issue && (((opcode == OP_BEQ) && (rd1 == rd2)) ||
                                   ((opcode == OP_BNE) && (rd1 != rd2)));
        o_jump         = issue && (opcode == OP_J);
        o_flush        = o_jump || o_branch_taken;
        o_branch_target = i_rst ? (i_PC + (addr_ext << 2)) : '0;
        o_dir_jump      = i_rst ? {i_PC[LEN-1:28], i_instruc[25:0], 2'b00} : '0;
    end

    always_comb begin
        idex_d       = '0;
        idex_d.valid = i_valid && !o_stall;
        idex_d.pc    = i_PC;
        idex_d.rd1   = rd1;
        idex_d.rd2   = rd2;
        idex_d.ext   = addr_ext;
        idex_d.rs    = rs;
        idex_d.rt    = rt;
        idex_d.rd    = rd;
        if (idex_d.valid) begin
            idex_d.wb = ctrl.wb;
            idex_d.m  = ctrl.m;
            idex_d.ex = ctrl.ex;
        end
        stall_count_d = stall_count_q;
        if (o_stall && (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            idex_q        <= '0;
            stall_count_q <= '0;
        end else begin
            idex_q        <= idex_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign o_valid        = idex_q.valid;
    assign o_PC           = idex_q.pc;
    assign o_read_data_1  = idex_q.rd1;
    assign o_read_data_2  = idex_q.rd2;
    assign o_addr_ext     = idex_q.ext;
    assign o_rs           = idex_q.rs;
    assign o_rt           = idex_q.rt;
    assign o_rd           = idex_q.rd;
    assign o_ctrl_wb_bus  = idex_q.wb;
    assign o_ctrl_mem_bus = idex_q.m;
    assign o_ctrl_exc_bus = idex_q.ex;
    assign o_stall_count  = stall_count_q;

endmodule
